// File: rtl/seq_detector_param.sv
// seq_detector_param: serial bit-sequence detector with run-time programmable
// pattern, length and overlap mode. Samples are qualified by in_valid. A
// registered one-cycle pulse on z flags each match, and match_cnt keeps a
// saturating count of matches since the last reset or configuration load.
module seq_detector_param #(
    parameter int unsigned          MAX_LEN     = 8,
    parameter logic [MAX_LEN-1:0]   DEF_PATTERN = 8'b0000_1001,
    parameter int unsigned          DEF_LEN     = 4,
    parameter bit                   DEF_OVERLAP = 1'b1,
    parameter int unsigned          CNT_W       = 8,
    localparam int unsigned         LEN_W       = $clog2(MAX_LEN) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic                x,
    input  logic                cfg_load,
    input  logic [MAX_LEN-1:0]  cfg_pattern,
    input  logic [LEN_W-1:0]    cfg_len,
    input  logic                cfg_overlap,
    output logic                z,
    output logic [CNT_W-1:0]    match_cnt
);

    localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_LEN);

    // StEmpty: fewer than len samples since the last clear; StPrimed: fill >= len.
    typedef enum logic [0:0] {StEmpty, StPrimed} state_e;

    state_e             state_q;
    logic [MAX_LEN-1:0] hist_q;
    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   fill_q;
    logic [LEN_W-1:0]   len_q;
    logic               overlap_q;
    logic               z_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [MAX_LEN-1:0] hist_next;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W-1:0]   fill_inc;
    logic [LEN_W-1:0]   fill_next;
    logic [LEN_W-1:0]   cfg_len_clamped;
    logic               accept;
    logic               enough;
    logic               match;

    // Match decision and next-state values for an accepted sample.
    always_comb begin
        hist_next = {hist_q[MAX_LEN-2:0], x};
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            len_mask[i] = (LEN_W'(i) < len_q);
        end
        fill_inc = fill_q + LEN_W'(1);
        // While EMPTY, fill < len, so fill+1 >= len only when fill+1 == len.
        enough   = (state_q == StPrimed) || (fill_inc == len_q);
        accept   = in_valid && !cfg_load;
        match    = accept && enough && (((hist_next ^ pattern_q) & len_mask) == '0);

        if (match && !overlap_q) begin
            fill_next = '0;
        end else if (fill_q == MaxLen) begin
            fill_next = MaxLen;
        end else begin
            fill_next = fill_inc;
        end

        if (cfg_len == '0) begin
            cfg_len_clamped = LEN_W'(1);
        end else if (cfg_len > MaxLen) begin
            cfg_len_clamped = MaxLen;
        end else begin
            cfg_len_clamped = cfg_len;
        end
    end

    // Detector state machine: reset, then configuration load, then sample accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StEmpty;
            hist_q    <= '0;
            fill_q    <= '0;
            pattern_q <= DEF_PATTERN;
            len_q     <= LEN_W'(DEF_LEN);
            overlap_q <= DEF_OVERLAP;
            z_q       <= 1'b0;
            cnt_q     <= '0;
        end else if (cfg_load) begin
            // History is kept; it is ignored until fill reaches len again.
            state_q   <= StEmpty;
            fill_q    <= '0;
            pattern_q <= cfg_pattern;
            len_q     <= cfg_len_clamped;
            overlap_q <= cfg_overlap;
            z_q       <= 1'b0;
            cnt_q     <= '0;
        end else if (in_valid) begin
            hist_q  <= hist_next;
            fill_q  <= fill_next;
            state_q <= (fill_next >= len_q) ? StPrimed : StEmpty;
            z_q     <= match;
            if (match && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else begin
            z_q <= 1'b0;
        end
    end

    assign z         = z_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios plus random traffic, all
// checked through an expected-response queue against a reference model that
// keeps the accepted bits since the last clear in a plain queue.
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_MAX = 255;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               in_valid = 1'b0;
    logic               x = 1'b0;
    logic               cfg_load = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic               z;
    logic [CNT_W-1:0]   match_cnt;

    seq_detector_param dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .x           (x),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .z           (z),
        .match_cnt   (match_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic z;
        int   cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state.
    bit [7:0] m_pat;
    int       m_len;
    bit       m_ovl;
    int       m_cnt;
    bit       m_bits[$];

    function automatic exp_t model(input bit r, input bit cl, input bit v, input bit xb,
                                   input bit [7:0] p, input int l, input bit o);
        exp_t e;
        bit   hit;
        e.z = 1'b0;
        if (r) begin
            m_pat = 8'h09;
            m_len = 4;
            m_ovl = 1'b1;
            m_cnt = 0;
            m_bits.delete();
        end else if (cl) begin
            m_pat = p;
            m_len = (l == 0) ? 1 : ((l > MAX_LEN) ? MAX_LEN : l);
            m_ovl = o;
            m_cnt = 0;
            m_bits.delete();
        end else if (v) begin
            m_bits.push_back(xb);
            if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
            hit = (m_bits.size() >= m_len);
            if (hit) begin
                for (int i = 0; i < m_len; i++) begin
                    if (m_bits[m_bits.size() - 1 - i] != m_pat[i]) hit = 1'b0;
                end
            end
            e.z = hit;
            if (hit && m_cnt < CNT_MAX) m_cnt++;
            if (hit && !m_ovl) m_bits.delete();
        end
        e.cnt = m_cnt;
        return e;
    endfunction

    task automatic step(input bit r, input bit cl, input bit v, input bit xb,
                        input logic [7:0] p, input logic [3:0] l, input bit o);
        exp_t e;
        @(negedge clk);
        rst         = r;
        cfg_load    = cl;
        in_valid    = v;
        x           = xb;
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        e = model(r, cl, v, xb, p, int'(l), o);
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
    endtask

    task automatic bit_in(input bit xb);
        step(1'b0, 1'b0, 1'b1, xb, 8'h00, 4'd0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input bit o);
        step(1'b0, 1'b1, 1'b0, 1'b0, p, l, o);
    endtask

    task automatic bits_in(input logic [7:0] seq, input int n);
        logic [7:0] s;
        s = seq;
        for (int i = n - 1; i >= 0; i--) bit_in(s[i]);
    endtask

    // Direct check of the counter after the edge that applies the last step.
    task automatic check_cnt(input string name, input int want);
        @(posedge clk);
        #2;
        checks++;
        if (match_cnt !== 8'(want)) begin
            errors++;
            $display("FAIL %s: match_cnt=%0d, required %0d", name, match_cnt, want);
        end
    endtask

    // Monitor: one expected response per edge, compared just after it.
    initial begin : monitor
        exp_t me;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                me = exp_q.pop_front();
                checks++;
                if (z !== me.z || match_cnt !== 8'(me.cnt)) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t: z=%b cnt=%0d, required z=%b cnt=%0d",
                             $time, z, match_cnt, me.z, me.cnt);
                end
            end
        end
    end

    initial begin : stimulus
        int         r;
        logic [3:0] l;

        do_reset();
        check_cnt("reset_cnt", 0);

        // Overlapping default detection of 1001 in 1001001.
        bits_in(8'b0100_1001, 7);
        check_cnt("t1_overlap_cnt", 2);

        // Non-overlapping mode on the same stream.
        load(8'h09, 4'd4, 1'b0);
        bits_in(8'b0100_1001, 7);
        check_cnt("t2_nonoverlap_cnt", 1);

        // Idle gaps between bits.
        load(8'h09, 4'd4, 1'b1);
        for (int i = 3; i >= 0; i--) begin
            bit_in(((4'b1001 >> i) & 4'b1) != 0);
            for (int k = 0; k < 3; k++) idle();
        end
        check_cnt("t3_gap_cnt", 1);

        // Length 1, counter saturation.
        load(8'h01, 4'd1, 1'b1);
        for (int i = 0; i < 300; i++) bit_in(1'b1);
        check_cnt("t4_sat_cnt", 255);

        // Load on the would-be final bit drops that bit and clears fill.
        load(8'h09, 4'd4, 1'b1);
        bits_in(8'b0000_0100, 3);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h09, 4'd4, 1'b1);
        check_cnt("t5_load_drop_cnt", 0);
        bits_in(8'b0000_1001, 4);
        check_cnt("t5_refill_cnt", 1);
        load(8'h01, 4'd0, 1'b1);
        bits_in(8'b0000_0111, 3);
        check_cnt("t5_len0_cnt", 3);
        load(8'hA5, 4'd12, 1'b1);
        bits_in(8'hA5, 8);
        check_cnt("t5_len12_cnt", 1);

        // Reset mid-pattern restores defaults.
        load(8'h03, 4'd2, 1'b0);
        bits_in(8'b0000_0100, 3);
        do_reset();
        bit_in(1'b1);
        check_cnt("t6_after_rst_cnt", 0);
        bits_in(8'b0000_0001, 3);
        check_cnt("t6_default_cfg_cnt", 1);

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            r = int'($urandom_range(0, 999));
            if (r < 5) begin
                do_reset();
            end else if (r < 35) begin
                l = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                : 4'($urandom_range(1, 4));
                step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     8'($urandom), l, 1'($urandom_range(0, 1)));
            end else begin
                step(1'b0, 1'b0, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                     8'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
            end
        end

        idle();
        idle();
        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses left, required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
